// File: rtl/pgm_rd.sv
// pgm_rd: forwards bypass packets from pgm_wr, or replays the packet held in
// PGM_RAM repeatedly with a programmable idle gap between copies.
module pgm_rd #(
  parameter string       PLATFORM   = "Xilinx",
  parameter logic [15:0] GAP_CYCLES = 16'd12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  input  logic          pgm_bypass_flag,
  input  logic          pgm_sent_start_flag,
  input  logic          pgm_sent_finish_flag,
  output logic          rd2ram_rd_en,
  output logic [6:0]    rd2ram_addr,
  input  logic [143:0]  ram2rd_rdata,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_alf,
  output logic [31:0]   pgm_sent_pkt_cnt
);
  typedef enum logic [2:0] {IDLE, BYPASS, SEND, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic            start_prev_q, start_prev_d, fin_prev_q, fin_prev_d;
  logic            fin_q, fin_d, pend_q, pend_d;
  logic [15:0]     gap_q, gap_d;
  logic            rd_en_q, rd_en_d, rvalid_q, rvalid_d, first_q, first_d;
  logic [6:0]      addr_q, addr_d, raddr_q, raddr_d;
  logic [1023:0]   phv_q, phv_d;
  logic [133:0]    data_q, data_d;
  logic            phv_wr_q, phv_wr_d, data_wr_q, data_wr_d;
  logic            valid_q, valid_d, valid_wr_q, valid_wr_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            start_edge, fin_edge, in_head, in_tail, r_tail, fwd;
  logic            unused_ok;

  assign unused_ok = ^{ram2rd_rdata[143:134], PLATFORM == "Xilinx"};

  assign rd2ram_rd_en     = rd_en_q;
  assign rd2ram_addr      = addr_q;
  assign out_rd_phv       = phv_q;
  assign out_rd_phv_wr    = phv_wr_q;
  assign out_rd_data      = data_q;
  assign out_rd_data_wr   = data_wr_q;
  assign out_rd_valid     = valid_q;
  assign out_rd_valid_wr  = valid_wr_q;
  assign pgm_sent_pkt_cnt = cnt_q;

  always_comb begin
    start_edge   = pgm_sent_start_flag & ~start_prev_q;
    fin_edge     = pgm_sent_finish_flag & ~fin_prev_q;
    in_head      = in_rd_data_wr && (in_rd_data[133:132] == 2'b01);
    in_tail      = in_rd_data_wr && (in_rd_data[133:132] == 2'b10);
    // RAM word returned this cycle closes the packet on a tail tag or the last address
    r_tail       = rvalid_q && ((ram2rd_rdata[133:132] == 2'b10) || (raddr_q == 7'd127));
    fwd          = 1'b0;
    state_d      = state_q;
    start_prev_d = pgm_sent_start_flag;
    fin_prev_d   = pgm_sent_finish_flag;
    fin_d        = fin_q | fin_edge;
    pend_d       = pend_q;
    gap_d        = gap_q;
    cnt_d        = cnt_q;
    rd_en_d      = 1'b0;
    addr_d       = 7'd0;
    rvalid_d     = rd_en_q;
    raddr_d      = addr_q;
    first_d      = first_q;
    phv_d        = '0;
    phv_wr_d     = 1'b0;
    data_d       = '0;
    data_wr_d    = 1'b0;
    valid_d      = 1'b0;
    valid_wr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_head && pgm_bypass_flag) begin
          fwd     = 1'b1;
          pend_d  = pend_q | start_edge;
          state_d = BYPASS;
        end else if (start_edge || pend_q) begin
          cnt_d   = '0;
          fin_d   = fin_edge;
          pend_d  = 1'b0;
          gap_d   = GAP_CYCLES;
          state_d = GAP;
        end
      end
      BYPASS: begin
        fwd    = 1'b1;
        pend_d = pend_q | start_edge;
        if (in_tail) state_d = IDLE;
      end
      GAP: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        // the count reaches zero at the end of this cycle, so the gap lasts GAP_CYCLES cycles
        if (gap_q <= 16'd1) begin
          if (fin_q) begin
            state_d = DONE;
          end else if (!in_rd_alf) begin
            rd_en_d = 1'b1;
            addr_d  = 7'd0;
            first_d = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (rvalid_q) begin
          data_d    = ram2rd_rdata[133:0];
          data_wr_d = 1'b1;
          phv_wr_d  = first_q;
          first_d   = 1'b0;
        end
        if (r_tail) begin
          valid_d    = 1'b1;
          valid_wr_d = 1'b1;
          cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
          gap_d      = GAP_CYCLES;
          state_d    = GAP;
        end else if (rd_en_q && (addr_q != 7'd127)) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 7'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fwd) begin
      phv_d      = in_rd_phv_wr ? in_rd_phv : '0;
      phv_wr_d   = in_rd_phv_wr;
      data_d     = in_rd_data_wr ? in_rd_data : '0;
      data_wr_d  = in_rd_data_wr;
      valid_d    = in_rd_valid_wr & in_rd_valid;
      valid_wr_d = in_rd_valid_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      fin_prev_q   <= 1'b0;
      fin_q        <= 1'b0;
      pend_q       <= 1'b0;
      gap_q        <= '0;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      rvalid_q     <= 1'b0;
      raddr_q      <= '0;
      first_q      <= 1'b0;
      phv_q        <= '0;
      phv_wr_q     <= 1'b0;
      data_q       <= '0;
      data_wr_q    <= 1'b0;
      valid_q      <= 1'b0;
      valid_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      fin_prev_q   <= fin_prev_d;
      fin_q        <= fin_d;
      pend_q       <= pend_d;
      gap_q        <= gap_d;
      cnt_q        <= cnt_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      rvalid_q     <= rvalid_d;
      raddr_q      <= raddr_d;
      first_q      <= first_d;
      phv_q        <= phv_d;
      phv_wr_q     <= phv_wr_d;
      data_q       <= data_d;
      data_wr_q    <= data_wr_d;
      valid_q      <= valid_d;
      valid_wr_q   <= valid_wr_d;
    end
  end
endmodule

// File: tb/tb_pgm_rd.sv
// tb_pgm_rd: randomized scoreboard bench for pgm_rd; the driver queues expected
// output words from a packet-level model, a negedge monitor pops and compares.
module tb_pgm_rd;
  localparam logic [15:0] GAP  = 16'd12;
  localparam int          GAPI = 12;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [1023:0] in_rd_phv = '0, out_rd_phv;
  logic          in_rd_phv_wr = 1'b0, out_rd_phv_wr;
  logic [133:0]  in_rd_data = '0, out_rd_data;
  logic          in_rd_data_wr = 1'b0, out_rd_data_wr;
  logic          in_rd_valid = 1'b0, in_rd_valid_wr = 1'b0, out_rd_valid, out_rd_valid_wr;
  logic          pgm_bypass_flag = 1'b0, pgm_sent_start_flag = 1'b0, pgm_sent_finish_flag = 1'b0;
  logic          rd2ram_rd_en, in_rd_alf = 1'b0;
  logic [6:0]    rd2ram_addr;
  logic [143:0]  ram2rd_rdata = '0;
  logic [31:0]   pgm_sent_pkt_cnt;

  pgm_rd #(.PLATFORM("Xilinx"), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr), .ram2rd_rdata(ram2rd_rdata),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
    .in_rd_alf(in_rd_alf), .pgm_sent_pkt_cnt(pgm_sent_pkt_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [143:0] mem [128];
  always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= mem[rd2ram_addr];

  typedef struct {
    logic          phv_wr;
    logic [1023:0] phv;
    logic          data_wr;
    logic [133:0]  data;
    logic          valid_wr;
    logic          valid;
    int            cnt;
    int            head_abs;
    bit            head_rel;
  } item_t;

  item_t sb[$];
  int    checks = 0, failures = 0;
  int    heads_seen = 0, last_tail = -1000, rd_count = 0;
  bit    noise = 0, byp_active = 0;

  function automatic logic [1023:0] rnd_phv();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [133:0] rnd_word(input logic [1:0] tag);
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom();
    return {tag, t[131:0]};
  endfunction

  // Read monitor: addresses of a read burst start at 0 and step by one, never wrapping.
  initial begin
    logic       prev_rd;
    logic [7:0] prev_addr, exp_addr;
    prev_rd = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rd2ram_rd_en) begin
        checks++;
        exp_addr = prev_rd ? prev_addr + 8'd1 : 8'd0;
        if ({1'b0, rd2ram_addr} != exp_addr) begin
          failures++;
          $display("FAIL rd_addr: cyc=%0d got addr %0d, required %0d", cyc, rd2ram_addr, exp_addr);
        end
        rd_count++;
      end
      prev_rd   = rd_en_or0();
      prev_addr = {1'b0, rd2ram_addr};
    end
  end

  function automatic logic rd_en_or0();
    return rst_n & rd2ram_rd_en;
  endfunction

  // Output monitor: pops one expected word per strobed output cycle.
  initial begin
    item_t e;
    bit    ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if ((!out_rd_phv_wr && out_rd_phv != '0) || (!out_rd_data_wr && out_rd_data != '0) ||
            (!out_rd_valid_wr && out_rd_valid)) begin
          failures++;
          $display("FAIL idle_zero: cyc=%0d data=%h with strobes %b%b%b, required zero data", cyc,
                   out_rd_data, out_rd_phv_wr, out_rd_data_wr, out_rd_valid_wr);
        end
        if (out_rd_phv_wr || out_rd_data_wr || out_rd_valid_wr) begin
          $display("out cyc=%0d wr=%b%b%b data=%h cnt=%0d", cyc, out_rd_phv_wr, out_rd_data_wr,
                   out_rd_valid_wr, out_rd_data, pgm_sent_pkt_cnt);
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out: cyc=%0d got data=%h, required no output", cyc, out_rd_data);
          end else begin
            e  = sb.pop_front();
            ok = (out_rd_phv_wr == e.phv_wr) && (out_rd_phv == e.phv) && (out_rd_data_wr == e.data_wr) &&
                 (out_rd_data == e.data) && (out_rd_valid_wr == e.valid_wr) && (out_rd_valid == e.valid);
            if (e.cnt >= 0 && pgm_sent_pkt_cnt != 32'(e.cnt)) ok = 0;
            if (e.head_abs >= 0 && cyc != e.head_abs) ok = 0;
            if (e.head_rel && cyc != last_tail + GAPI + 2) ok = 0;
            if (!ok) begin
              failures++;
              $display("FAIL out_word: cyc=%0d got wr=%b%b%b data=%h v=%b phv[63:0]=%h cnt=%0d; required wr=%b%b%b data=%h v=%b phv[63:0]=%h cnt=%0d abs_cyc=%0d rel=%0d",
                       cyc, out_rd_phv_wr, out_rd_data_wr, out_rd_valid_wr, out_rd_data, out_rd_valid,
                       out_rd_phv[63:0], pgm_sent_pkt_cnt, e.phv_wr, e.data_wr, e.valid_wr, e.data,
                       e.valid, e.phv[63:0], e.cnt, e.head_abs, e.head_rel ? last_tail + GAPI + 2 : -1);
            end
          end
          if (out_rd_phv_wr) heads_seen++;
          if (out_rd_valid_wr) last_tail = cyc;
        end
      end
    end
  end

  task automatic drive_idle();
    in_rd_phv_wr = 1'b0; in_rd_data_wr = 1'b0; in_rd_valid_wr = 1'b0;
    in_rd_phv = rnd_phv(); in_rd_data = rnd_word(2'b01); in_rd_valid = 1'($urandom());
  endtask

  task automatic step();
    @(negedge clk);
    if (noise) begin
      pgm_bypass_flag = 1'b1;
      in_rd_phv_wr = 1'($urandom()); in_rd_data_wr = 1'($urandom()); in_rd_valid_wr = 1'($urandom());
      in_rd_phv = rnd_phv(); in_rd_data = rnd_word(2'($urandom())); in_rd_valid = 1'($urandom());
    end else drive_idle();
  endtask

  // Bypass model: a head with bypass_flag opens a packet in which every strobed word is forwarded.
  task automatic send_word(input logic pw, input logic [1:0] tag, input logic dw, input logic vw);
    item_t it;
    bit    fwd;
    @(negedge clk);
    drive_idle();
    in_rd_phv_wr = pw; in_rd_data_wr = dw; in_rd_valid_wr = vw;
    in_rd_data = rnd_word(tag);
    fwd = byp_active || (dw && tag == 2'b01 && pgm_bypass_flag);
    if (fwd) begin
      if (pw || dw || vw) begin
        it.phv_wr = pw; it.phv = pw ? in_rd_phv : '0;
        it.data_wr = dw; it.data = dw ? in_rd_data : '0;
        it.valid_wr = vw; it.valid = vw & in_rd_valid;
        it.cnt = -1; it.head_abs = -1; it.head_rel = 0;
        sb.push_back(it);
      end
      byp_active = !(dw && tag == 2'b10);
    end
  endtask

  task automatic bypass_pkt(input int nbody);
    send_word(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < nbody; i++) begin
      send_word(1'b0, 2'b11, 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) send_word(1'b0, 2'b11, 1'b0, 1'b0);
    end
    send_word(1'b0, 2'b10, 1'b1, 1'b1);
  endtask

  // len=0 leaves the RAM without any tail tag.
  task automatic load_mem(input int len);
    for (int a = 0; a < 128; a++) begin
      logic [1:0] tag;
      tag = (a == 0) ? 2'b01 : ((a == len - 1) ? 2'b10 : 2'b11);
      mem[a] = {10'($urandom()), rnd_word(tag)};
    end
  endtask

  // Generated packet: RAM words from address 0 up to the first tail tag or address 127.
  task automatic push_gen(input int k, input int head_abs, input bit head_rel);
    item_t it;
    bit    last;
    for (int a = 0; a < 128; a++) begin
      last = (mem[a][133:132] == 2'b10) || (a == 127);
      it.phv_wr = (a == 0); it.phv = '0;
      it.data_wr = 1'b1; it.data = mem[a][133:0];
      it.valid_wr = last; it.valid = last;
      it.cnt = last ? k : -1;
      it.head_abs = (a == 0) ? head_abs : -1;
      it.head_rel = (a == 0) && head_rel;
      sb.push_back(it);
      if (last) break;
    end
  endtask

  task automatic pulse_start(output int c);
    @(negedge clk); drive_idle(); pgm_sent_start_flag = 1'b1; c = cyc;
    @(negedge clk); drive_idle(); pgm_sent_start_flag = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clk); drive_idle(); pgm_sent_finish_flag = 1'b1;
    @(negedge clk); drive_idle(); pgm_sent_finish_flag = 1'b0;
  endtask

  task automatic wait_heads(input int n, input int budget, input string nm);
    int i = 0;
    while (heads_seen < n && i < budget) begin step(); i++; end
    checks++;
    if (heads_seen < n) begin
      failures++;
      $display("FAIL %s: heads seen %0d after %0d cycles, required %0d", nm, heads_seen, budget, n);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin step(); i++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d words still pending, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_reads(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d reads, required %0d", nm, got, req);
    end
  endtask

  task automatic settle_done(input string nm, input int k);
    int snap;
    snap = rd_count;
    repeat (GAPI + 10) step();
    expect_reads(nm, rd_count - snap, 0);
    checks++;
    if (pgm_sent_pkt_cnt != 32'(k)) begin
      failures++;
      $display("FAIL %s_cnt: got pkt_cnt %0d, required %0d", nm, pgm_sent_pkt_cnt, k);
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if ({rd2ram_rd_en, rd2ram_addr, out_rd_phv, out_rd_phv_wr, out_rd_data, out_rd_data_wr,
         out_rd_valid, out_rd_valid_wr, pgm_sent_pkt_cnt} != '0) begin
      failures++;
      $display("FAIL %s: got rd_en=%b addr=%0d wr=%b%b%b data=%h cnt=%0d, required all zero", nm,
               rd2ram_rd_en, rd2ram_addr, out_rd_phv_wr, out_rd_data_wr, out_rd_valid_wr, out_rd_data,
               pgm_sent_pkt_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, h, snap;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Bypass packets of random length; one with bypass_flag low is dropped entirely.
    for (int p = 0; p < 6; p++) begin
      pgm_bypass_flag = (p != 2);
      bypass_pkt($urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) step();
    end
    drain("bypass_drain", 20);

    // Repeated generation of a 4-word RAM packet, finish raised mid-packet.
    load_mem(4);
    pulse_start(c);
    push_gen(1, c + 3 + GAPI, 0);
    for (int k = 2; k <= 4; k++) push_gen(k, -1, 1);
    noise = 1;
    wait_heads(heads_seen + 4, 400, "gen_heads");
    noise = 0;
    pulse_finish();
    drain("gen_drain", 100);
    settle_done("gen_done", 4);

    // Almost-full held across gap expiry, then released; alf mid-packet does not stop it.
    load_mem($urandom_range(2, 6));
    in_rd_alf = 1'b1;
    snap = rd_count;
    h = heads_seen;
    pulse_start(c);
    repeat (GAPI + 20) step();
    expect_reads("alf_hold", rd_count - snap, 0);
    push_gen(1, -1, 0);
    in_rd_alf = 1'b0;
    wait_heads(h + 1, 40, "alf_release");
    in_rd_alf = 1'b1;
    pulse_finish();
    drain("alf_drain", 60);
    in_rd_alf = 1'b0;
    settle_done("alf_done", 1);

    // RAM without a tail: stop after address 127, no wrap.
    load_mem(0);
    snap = rd_count;
    pulse_start(c);
    push_gen(1, c + 3 + GAPI, 0);
    wait_heads(heads_seen + 1, 60, "full_head");
    pulse_finish();
    drain("full_drain", 300);
    expect_reads("full_reads", rd_count - snap, 128);
    settle_done("full_done", 1);

    // Reset in the middle of a generated packet.
    load_mem(8);
    pulse_start(c);
    push_gen(1, -1, 0);
    wait_heads(heads_seen + 1, 60, "rst_head");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_send");
    sb.delete();
    byp_active = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap = rd_count;
    repeat (40) step();
    expect_reads("rst_quiet", rd_count - snap, 0);

    // Start edge arriving during a bypass packet is honoured once it ends.
    pgm_bypass_flag = 1'b1;
    h = heads_seen;
    send_word(1'b1, 2'b01, 1'b1, 1'b0);
    send_word(1'b0, 2'b11, 1'b1, 1'b0);
    pgm_sent_start_flag = 1'b1;
    send_word(1'b0, 2'b11, 1'b1, 1'b0);
    pgm_sent_start_flag = 1'b0;
    send_word(1'b0, 2'b10, 1'b1, 1'b1);
    push_gen(1, -1, 0);
    wait_heads(h + 2, 60, "pend_heads");
    pulse_finish();
    drain("pend_drain", 60);
    settle_done("pend_done", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pgm_rd.md
PGM_RD -- requirements
Module: pgm_rd

Interface
REQ-001 SHALL have parameter PLATFORM, default "Xilinx", target vendor tag.
REQ-002 SHALL have parameter GAP_CYCLES, default 16'd12, idle cycles inserted between generated packets.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning.
 clk  in  1  single clock.
 rst_n  in  1  asynchronous, active-low reset.
 in_rd_phv / in_rd_phv_wr  in  1024/1  bypass PHV and its strobe from pgm_wr.
 in_rd_data / in_rd_data_wr  in  134/1  bypass data word ([133:132]: 01 head, 11 body, 10 tail) and its strobe.
 in_rd_valid / in_rd_valid_wr  in  1/1  packet-valid flag and its strobe.
 pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag  in  1 each  control flags from pgm_wr.
 rd2ram_rd_en  out  1  PGM_RAM read enable.
 rd2ram_addr  out  7  PGM_RAM read address.
 ram2rd_rdata  in  144  PGM_RAM read data, valid one cycle after rd2ram_rd_en.
 out_rd_phv / out_rd_phv_wr  out  1024/1  PHV and strobe to the next module.
 out_rd_data / out_rd_data_wr  out  134/1  data and strobe to the next module.
 out_rd_valid / out_rd_valid_wr  out  1/1  valid flag and strobe to the next module.
 in_rd_alf  in  1  downstream almost-full.
 pgm_sent_pkt_cnt  out  32  count of generated packets since the last start.

Function
REQ-004 SHALL implement states IDLE, BYPASS, SEND, GAP, and DONE.
REQ-005 IDLE: if in_rd_data_wr=1 with [133:132]=01 and pgm_bypass_flag=1, SHALL register in_rd_phv, in_rd_data, and in_rd_valid to the outputs with their strobes, then go to BYPASS.
REQ-006 BYPASS: each in_rd_* word/strobe SHALL be forwarded with exactly 1 cycle latency, unmodified; on a forwarded tail, SHALL return to IDLE.
REQ-007 A rising edge of pgm_sent_start_flag (registered edge detect) SHALL, in IDLE:
 - clear pgm_sent_pkt_cnt;
 - clear the finish latch;
 - go to GAP with its counter preloaded to GAP_CYCLES, so the first packet starts after the normal gap.
REQ-008 A rising edge of pgm_sent_start_flag seen in BYPASS SHALL be held pending and acted on when BYPASS returns to IDLE.
REQ-009 GAP: SHALL decrement the counter by 1 per cycle.
 - At 0 with the finish latch set: go to DONE.
 - At 0 with in_rd_alf=0: set rd2ram_rd_en=1 and rd2ram_addr=0, then go to SEND.
 - At 0 with in_rd_alf=1: hold, issuing no read.
REQ-010 SEND: SHALL issue rd2ram_rd_en=1 every cycle with rd2ram_addr incrementing by 1.
REQ-011 SEND output timing: each returned ram2rd_rdata[133:0] SHALL appear on out_rd_data with out_rd_data_wr=1 one cycle after it returns; ram2rd_rdata[143:134] SHALL be ignored.
REQ-012 SEND stopping: on a returned word with [133:132]=10, or after address 127 has been read, reads SHALL stop and that word SHALL be emitted as the tail.
REQ-013 SEND discard: a word issued speculatively past the tail SHALL be discarded.
REQ-014 Generated-packet output: SHALL drive out_rd_phv=0 with out_rd_phv_wr=1 on the head cycle, and out_rd_valid=1 with out_rd_valid_wr=1 on the tail cycle.
REQ-015 On each generated tail, pgm_sent_pkt_cnt SHALL increment (saturating at 32'hFFFFFFFF) and the state SHALL go to GAP with the counter reloaded to GAP_CYCLES.
REQ-016 A packet in SEND SHALL always complete; in_rd_alf SHALL be sampled only at packet start.
REQ-017 A rising edge of pgm_sent_finish_flag in any state SHALL set the finish latch; generation SHALL stop only at a packet boundary.
REQ-018 In GAP and SEND, in_rd_* input words SHALL be dropped.
REQ-019 DONE: all strobes SHALL be 0, pgm_sent_pkt_cnt SHALL hold, and the next cycle SHALL go to IDLE.
REQ-020 All strobes SHALL be single-cycle pulses; when a strobe is 0, its data output SHALL be 0.

Reset
REQ-021 On rst_n=0, asynchronously, all outputs SHALL be 0, the state SHALL be IDLE, and the edge detectors, finish latch, pending start, and gap counter SHALL be cleared.
REQ-022 Reset asserted mid-packet SHALL abort the packet with no tail emitted; after release, the block SHALL wait for a new start edge.

Verification
REQ-023 Bypass 3-word packet (01, 11, 10), bypass_flag=1 -> identical words out, 1 cycle later; phv_wr on head; valid_wr=1 on tail only.
REQ-024 RAM preloaded with a 4-word packet, start edge, GAP_CYCLES=12 -> head at addr 0 read after 12 gap cycles; 4 out words back-to-back; gap of 12 cycles before the next head; pkt_cnt 1, 2, 3...
REQ-025 in_rd_alf=1 held at gap expiry for 20 cycles -> no read and no output until alf=0; the following packet is intact.
REQ-026 Finish edge mid-packet -> current packet completes with tail, pkt_cnt increments once, DONE then IDLE, no further reads.
REQ-027 RAM holding 128 words with no tail -> reads stop after addr 127; addr-127 word emitted with valid_wr=1; no wrap to addr 0 within the packet.
REQ-028 rst_n pulsed low mid-SEND -> all outputs immediately 0; no output after release until a new start edge.
